// File: rtl/dram_burst_reader.sv
// AXI4 INCR read master: splits a kick command into 4KB/MAX_BURST-bounded bursts, one outstanding.
// Optional rresp/rlast checking with sticky rd_err when DRAM_READER_ERRCHK_EN is defined.
module dram_burst_reader #(
  parameter int MAX_BURST  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kick,
  input  logic [31:0]           read_addr,
  input  logic [31:0]           read_num,
  output logic                  busy,
  output logic [31:0]           buf_dout,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  rd_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [8:0]  MAX_LEN  = 9'(MAX_BURST);
  localparam logic [31:0] MAX_LEN32 = 32'(MAX_BURST);

  state_t      state_q, state_d;
  logic [29:0] cur_word_q, cur_word_d;
  logic [31:0] remaining_q, remaining_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] buf_dout_q, buf_dout_d;
  logic        buf_we_q, buf_we_d;

  logic [10:0] bound_words;
  logic [8:0]  cap_len;
  logic [8:0]  beats;
  logic        last_beat;
  logic        r_fire;

  logic unused_addr;
  assign unused_addr = ^read_addr[1:0];

  // Burst length is derived from the latched registers, so it stays stable through ADDR and DATA.
  always_comb begin
    bound_words = 11'd1024 - {1'b0, cur_word_q[9:0]};
    cap_len     = (remaining_q > MAX_LEN32) ? MAX_LEN : remaining_q[8:0];
    beats       = ({2'b00, cap_len} > bound_words) ? bound_words[8:0] : cap_len;
    last_beat   = (beat_cnt_q == beats - 9'd1);
    r_fire      = (state_q == S_DATA) && m_axi_rvalid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_word_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      buf_dout_q  <= '0;
      buf_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_word_q  <= cur_word_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      buf_dout_q  <= buf_dout_d;
      buf_we_q    <= buf_we_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_word_d    = cur_word_q;
    remaining_d   = remaining_q;
    beat_cnt_d    = beat_cnt_q;
    buf_dout_d    = buf_dout_q;
    buf_we_d      = 1'b0;
    busy          = (state_q != S_IDLE);
    m_axi_arvalid = (state_q == S_ADDR);
    m_axi_rready  = (state_q == S_DATA);
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = 3'b010;
    m_axi_arburst = 2'b01;
    buf_dout      = buf_dout_q;
    buf_we        = buf_we_q;

    case (state_q)
      S_IDLE: begin
        if (kick && (read_num != 32'd0)) begin
          cur_word_d  = read_addr[31:2];
          remaining_d = read_num;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        m_axi_araddr = ADDR_WIDTH'({cur_word_q, 2'b00});
        m_axi_arlen  = 8'(beats - 9'd1);
        if (m_axi_arready) begin
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        // Burst end follows the internal beat count; rlast is only checked, never trusted.
        if (r_fire) begin
          buf_we_d   = 1'b1;
          buf_dout_d = m_axi_rdata;
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (last_beat) begin
            cur_word_d  = cur_word_q + 30'(beats);
            remaining_d = remaining_q - 32'(beats);
            state_d     = (remaining_q == 32'(beats)) ? S_DONE : S_ADDR;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DRAM_READER_ERRCHK_EN
  logic rd_err_q, rd_err_d;

  always_ff @(posedge clk) begin
    if (rst) rd_err_q <= 1'b0;
    else     rd_err_q <= rd_err_d;
  end

  always_comb begin
    rd_err_d = rd_err_q;
    if (r_fire && ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat))) rd_err_d = 1'b1;
  end

  assign rd_err = rd_err_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^{m_axi_rresp, m_axi_rlast};
  assign rd_err     = 1'b0;
`endif

endmodule
